// File: rtl/i2c_master_tx.sv
// Single-master I2C write initiator: START, 7-bit address + W, one data byte, STOP.
// SCL is derived from clk in quarter-periods of DIV clocks; SDA is open-drain.
//
// state   | meaning
// IDLE    | bus released, waiting for start
// START   | SDA falls while SCL high, then SCL low
// ADDR    | address bits 6..0 then R/W=0
// ACK1    | address ACK slot, SDA released
// DATA    | data bits 7..0
// ACK2    | data ACK slot, SDA released
// STOP    | SDA rises while SCL high
module i2c_master_tx #(
    parameter int DIV = 125
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       scl,
    inout  wire        sda
);

    localparam int QW = $clog2(DIV);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ACK1,
        ST_DATA,
        ST_ACK2,
        ST_STOP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    q;
    logic [2:0]    bitcnt;
    logic [6:0]    addr_r;
    logic [7:0]    wdata_r;
    logic [7:0]    addr_byte;
    logic          sda_hold;
    logic          sda_low;
    logic          scl_c;
    logic          tx_bit;
    logic          q_end;
    logic          slot_end;

    assign addr_byte = {addr_r, 1'b0};
    assign q_end     = (qcnt == QW'(DIV - 1));
    assign slot_end  = q_end && (q == 2'd3);
    assign scl       = scl_c;
    assign sda       = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_low   = 1'b0;
        tx_bit    = (state == ST_DATA) ? wdata_r[bitcnt] : addr_byte[bitcnt];
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_START;
            end
            ST_START: begin
                scl_c   = (q != 2'd3);
                sda_low = q[1];
                if (slot_end) state_nxt = ST_ADDR;
            end
            ST_ADDR, ST_DATA: begin
                // Q0 keeps whatever was on the line at the end of the previous slot
                scl_c   = q[1];
                sda_low = (q == 2'd0) ? sda_hold : !tx_bit;
                if (slot_end && bitcnt == 3'd0)
                    state_nxt = (state == ST_ADDR) ? ST_ACK1 : ST_ACK2;
            end
            ST_ACK1, ST_ACK2: begin
                scl_c   = q[1];
                sda_low = (q == 2'd0) ? sda_hold : 1'b0;
                if (slot_end) begin
                    if (state == ST_ACK1 && !ack_err) state_nxt = ST_DATA;
                    else                               state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                scl_c   = (q != 2'd0);
                sda_low = !q[1];
                if (slot_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            qcnt     <= '0;
            q        <= 2'd0;
            bitcnt   <= 3'd0;
            addr_r   <= 7'd0;
            wdata_r  <= 8'd0;
            sda_hold <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            sda_hold <= sda_low;
            done     <= (state == ST_STOP) && slot_end;
            if (state == ST_IDLE) begin
                qcnt <= '0;
                q    <= 2'd0;
                if (start) begin
                    addr_r  <= addr;
                    wdata_r <= wdata;
                    ack_err <= 1'b0;
                    busy    <= 1'b1;
                end
            end else begin
                qcnt <= q_end ? '0 : qcnt + 1'b1;
                if (q_end) q <= q + 2'd1;
                if (state == ST_STOP && slot_end) busy <= 1'b0;
                // ACK bit is taken on the last clock of Q2, mid SCL-high
                if ((state == ST_ACK1 || state == ST_ACK2) && q == 2'd2 && q_end && sda)
                    ack_err <= 1'b1;
            end
            if (state_nxt != state && (state_nxt == ST_ADDR || state_nxt == ST_DATA))
                bitcnt <= 3'd7;
            else if (slot_end && (state == ST_ADDR || state == ST_DATA))
                bitcnt <= bitcnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_i2c_master_tx.sv
// Scoreboard bench for i2c_master_tx: stimulus queues expected transfers, a bus
// monitor with a small ACKing slave pops and checks them on each done pulse.
module tb_i2c_master_tx;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] addr = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       scl;
    wire        sda_line;
    logic       slave_low = 1'b0;

    pullup (sda_line);
    assign sda_line = slave_low ? 1'b0 : 1'bz;

    i2c_master_tx #(.DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .addr    (addr),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .scl     (scl),
        .sda     (sda_line)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] lat;
        logic [31:0] err;
        logic [31:0] nrise;
        logic [31:0] nfall;
        logic [31:0] bits;
        logic [31:0] gap;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] plan_q[$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // expected bus bits are the SDA values seen at each SCL rise
    task automatic expect_xfer(input logic [6:0] a, input logic [7:0] d,
                               input logic a1, input logic a2, input int gap);
        exp_t e;
        e.lat   = a1 ? 32'(80 * DIV) : 32'(44 * DIV);
        e.err   = (a1 && a2) ? 32'd0 : 32'd1;
        e.nrise = a1 ? 32'd19 : 32'd10;
        e.nfall = a1 ? 32'd19 : 32'd10;
        e.bits  = a1 ? 32'({a, 1'b0, 1'b0, d, !a2, 1'b0}) : 32'({a, 1'b0, 1'b1, 1'b0});
        e.gap   = 32'(gap);
        sb.push_back(e);
        plan_q.push_back({a1, a2});
    endtask

    task automatic issue(input logic [6:0] a, input logic [7:0] d,
                         input logic a1, input logic a2, input int gap, input bit hold);
        expect_xfer(a, d, a1, a2, gap);
        @(negedge clk);
        addr  = a;
        wdata = d;
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            errors++;
            $display("FAIL wait_idle timeout pending=%0d busy=%0b", sb.size(), busy);
        end
    endtask

    int          cyc = 0;
    int          acc_cyc = 0;
    int          last_done = 0;
    int          n_start, n_stop, nrise, nfall, sfall;
    logic [31:0] bits;
    logic [1:0]  plan = 2'b00;
    logic        scl_p = 1'b1, sda_p = 1'b1, busy_p = 1'b0;
    exp_t        e_m;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            scl_p     = 1'b1;
            sda_p     = 1'b1;
            busy_p    = 1'b0;
            slave_low = 1'b0;
            sfall     = 0;
        end else begin
            if (busy && !busy_p) begin
                chk("accept_expected", 32'(sb.size() > 0), 32'd1);
                chk("ack_err_clear_on_accept", 32'(ack_err), 32'd0);
                acc_cyc = cyc;
                n_start = 0;
                n_stop  = 0;
                nrise   = 0;
                nfall   = 0;
                bits    = 32'd0;
            end
            if (scl_p && scl && sda_p && !sda_line) begin
                n_start++;
                sfall = 0;
                plan  = (plan_q.size() > 0) ? plan_q.pop_front() : 2'b00;
            end
            if (scl_p && scl && !sda_p && sda_line) n_stop++;
            if (!scl_p && scl) begin
                nrise++;
                bits = {bits[30:0], sda_line};
            end
            if (scl_p && !scl) begin
                nfall++;
                sfall++;
                slave_low = (sfall == 9 && plan[1]) || (sfall == 18 && plan[0]);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_expected", 32'd0, 32'd1);
                end else begin
                    e_m = sb.pop_front();
                    chk("latency", 32'(cyc - acc_cyc), e_m.lat);
                    chk("ack_err", 32'(ack_err), e_m.err);
                    chk("scl_rises", 32'(nrise), e_m.nrise);
                    chk("scl_falls", 32'(nfall), e_m.nfall);
                    chk("bus_bits", bits, e_m.bits);
                    chk("start_conditions", 32'(n_start), 32'd1);
                    chk("stop_conditions", 32'(n_stop), 32'd1);
                    if (e_m.gap != 0) chk("done_spacing", 32'(cyc - last_done), e_m.gap);
                end
                chk("busy_drop_with_done", 32'(busy), 32'd0);
                last_done = cyc;
            end
            scl_p  = scl;
            sda_p  = sda_line;
            busy_p = busy;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        chk("rst_scl", 32'(scl), 32'd1);
        chk("rst_sda", 32'(sda_line), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        issue(7'h50, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
        wait_idle();

        issue(7'h3C, 8'h81, 1'b0, 1'b1, 0, 1'b0);
        wait_idle();
        repeat (5) @(negedge clk);
        chk("ack_err_holds", 32'(ack_err), 32'd1);

        issue(7'h21, 8'h7E, 1'b1, 1'b0, 0, 1'b0);
        wait_idle();
        issue(7'h11, 8'h0F, 1'b1, 1'b1, 0, 1'b0);
        wait_idle();

        // start pulse mid-transfer with different payload must be ignored
        issue(7'h2A, 8'hC3, 1'b1, 1'b1, 0, 1'b0);
        repeat (48) @(negedge clk);
        addr  = 7'h55;
        wdata = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset inside DATA bit 3 (slot 14 of the transfer)
        issue(7'h50, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
        repeat (228) @(negedge clk);
        chk("busy_before_rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        plan_q.delete();
        chk("midrst_scl", 32'(scl), 32'd1);
        chk("midrst_sda", 32'(sda_line), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_ack_err", 32'(ack_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        issue(7'h50, 8'hA5, 1'b1, 1'b1, 0, 1'b0);
        wait_idle();

        // start held high: three back-to-back transfers
        expect_xfer(7'h6B, 8'h5A, 1'b1, 1'b1, 0);
        expect_xfer(7'h6B, 8'h5A, 1'b1, 1'b1, 80 * DIV + 1);
        issue(7'h6B, 8'h5A, 1'b1, 1'b1, 80 * DIV + 1, 1'b1);
        n = 0;
        while (sb.size() > 1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            errors++;
            $display("FAIL back_to_back timeout pending=%0d", sb.size());
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
